// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, opcode encodings and the
// arbiter FSM state type.
package alu_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;

    // Opcode encodings shared with the ALU; the arbiter passes them through unchecked.
    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_SUB = 4'h1;
    localparam logic [OPW-1:0] OP_AND = 4'h2;
    localparam logic [OPW-1:0] OP_OR  = 4'h3;
    localparam logic [OPW-1:0] OP_XOR = 4'h4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after
// 'last' (circular) wins.
// Ports:
//   req    in   NREQ  request vector
//   last   in   IW    index of the previously served requester
//   grant  out  NREQ  one-hot winner (all-zero when no request)
//   idx    out  IW    binary index of the winner
//   any    out  1     at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic          found;
    logic [IW-1:0] cand;

    // Scan from last+1 around to last itself; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        any   = |req;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares a single ALU among NREQ requesters. One op at a time: round-robin
// accept, one-cycle ALU enable, wait ALU_LAT cycles, capture the result and
// return it to the owner over a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        per-requester request handshake (ready is one-hot, IDLE only)
//   req_a/req_b/req_op         packed operands/opcode, requester i at [i*W +: W]
//   rsp_valid/rsp_ready        per-requester response handshake (valid is one-hot to owner)
//   rsp_result/rsp_cf          captured ALU result and carry, shared bus
//   alu_enable                 one-cycle enable pulse to the ALU
//   alu_data_a/b, alu_opcode   latched operands to the ALU
//   alu_results/alu_cf         ALU outputs
//   busy                       high whenever the FSM is not IDLE
module alu_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = alu_pkg::DW,
    parameter int unsigned OPW     = alu_pkg::OPW,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_result,
    output logic              rsp_cf,
    output logic              alu_enable,
    output logic [DW-1:0]     alu_data_a,
    output logic [DW-1:0]     alu_data_b,
    output logic [OPW-1:0]    alu_opcode,
    input  logic [DW-1:0]     alu_results,
    input  logic              alu_cf,
    output logic              busy
);

    import alu_pkg::*;

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] owner_q;
    logic [CW-1:0] cnt_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            any_req;
    logic            accept;
    logic            capture;
    logic            ack;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req_valid),
        .last  (last_grant_q),
        .grant (grant),
        .idx   (gidx),
        .any   (any_req)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; req_ready is forced low while in reset.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        ack       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    req_ready = grant & {NREQ{rst_n}};
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; timed off state_d so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(NREQ - 1);
            owner_q      <= '0;
            cnt_q        <= '0;
            alu_enable   <= 1'b0;
            alu_data_a   <= '0;
            alu_data_b   <= '0;
            alu_opcode   <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_cf       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            alu_enable <= (state_d == ISSUE);
            busy       <= (state_d != IDLE);
            rsp_valid  <= (state_d == RESP) ? (NREQ'(1) << owner_q) : '0;

            if (accept) begin
                owner_q    <= gidx;
                alu_data_a <= req_a[32'(gidx)*DW +: DW];
                alu_data_b <= req_b[32'(gidx)*DW +: DW];
                alu_opcode <= req_op[32'(gidx)*OPW +: OPW];
            end

            // Counter reaches zero on the cycle the ALU output becomes valid.
            if (state_q == ISSUE) begin
                cnt_q <= CW'(ALU_LAT - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (capture) begin
                rsp_result <= alu_results;
                rsp_cf     <= alu_cf;
            end

            if (ack) begin
                last_grant_q <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance with ALU_LAT=1
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [15:0] rsp_result, alu_data_a, alu_data_b, alu_results;
    logic        rsp_cf, alu_enable, alu_cf, busy;
    logic [3:0]  alu_opcode;

    // Instance with ALU_LAT=3
    logic [1:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [31:0] req_a3, req_b3;
    logic [7:0]  req_op3;
    logic [15:0] rsp_result3, alu_data_a3, alu_data_b3, alu_results3;
    logic        rsp_cf3, alu_enable3, alu_cf3, busy3;
    logic [3:0]  alu_opcode3;

    int n_total = 0;
    int n_bad   = 0;

    alu_arbiter #(.NREQ(2), .DW(16), .OPW(4), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cf(rsp_cf),
        .alu_enable(alu_enable), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .alu_opcode(alu_opcode), .alu_results(alu_results), .alu_cf(alu_cf),
        .busy(busy)
    );

    alu_arbiter #(.NREQ(2), .DW(16), .OPW(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_cf(rsp_cf3),
        .alu_enable(alu_enable3), .alu_data_a(alu_data_a3), .alu_data_b(alu_data_b3),
        .alu_opcode(alu_opcode3), .alu_results(alu_results3), .alu_cf(alu_cf3),
        .busy(busy3)
    );

    function automatic logic [16:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return 17'h0;
        endcase
    endfunction

    // Behavioural ALUs: output is only meaningful exactly LAT cycles after Enable, 0xDEAD otherwise.
    logic        v1;
    logic [16:0] d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= alu_enable;
            d1 <= alu_calc(alu_opcode, alu_data_a, alu_data_b);
        end
    end
    assign alu_results = v1 ? d1[15:0] : 16'hDEAD;
    assign alu_cf      = v1 & d1[16];

    logic [2:0]  v3;
    logic [16:0] d3 [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= '0;
            d3[0] <= '0; d3[1] <= '0; d3[2] <= '0;
        end else begin
            v3    <= {v3[1:0], alu_enable3};
            d3[0] <= alu_calc(alu_opcode3, alu_data_a3, alu_data_b3);
            d3[1] <= d3[0];
            d3[2] <= d3[1];
        end
    end
    assign alu_results3 = v3[2] ? d3[2][15:0] : 16'hDEAD;
    assign alu_cf3      = v3[2] & d3[2][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp();
        int w;
        w = 0;
        while (rsp_valid == 2'b00 && w < 30) begin
            @(negedge clk); #1;
            w++;
        end
        chk("rsp_seen", 32'(rsp_valid != 2'b00), 32'd1);
    endtask

    task automatic set_ops(input int i, input int k);
        req_a[i*16 +: 16] = 16'((i << 12) | (k << 4) | 1);
        req_b[i*16 +: 16] = (i == 1) ? 16'hF000 : 16'h0100;
        req_op[i*4 +: 4]  = OP_ADD;
    endtask

    // Full single op from requester r on the ALU_LAT=1 instance.
    task automatic do_op(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input string tag);
        logic [16:0] e;
        int w;
        e = alu_calc(op, a, b);
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_a[r*16 +: 16] = a;
        req_b[r*16 +: 16] = b;
        req_op[r*4 +: 4]  = op;
        #1;
        w = 0;
        while (!req_ready[r] && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        chk({tag, "_accept"}, 32'(req_ready), 32'd1 << r);
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        wait_rsp();
        chk({tag, "_owner"}, 32'(rsp_valid), 32'd1 << r);
        chk({tag, "_res"}, 32'(rsp_result), 32'(e[15:0]));
        chk({tag, "_cf"}, 32'(rsp_cf), 32'(e[16]));
        rsp_ready = rsp_valid;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [2];
        int w;
        int g;
        logic [16:0] e;

        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(alu_enable), 32'd0);
        chk("rst_data_a", 32'(alu_data_a), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_data_a3", 32'(alu_data_a3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: single ADD from req0, cycle-exact
        @(negedge clk);
        req_valid = 2'b01; req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0004; req_op[3:0] = OP_ADD;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("t1_enable", 32'(alu_enable), 32'd1);
        chk("t1_data_a", 32'(alu_data_a), 32'h3);
        chk("t1_data_b", 32'(alu_data_b), 32'h4);
        chk("t1_busy1", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("t1_enable_drop", 32'(alu_enable), 32'd0);
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_result", 32'(rsp_result), 32'h7);
        chk("t1_cf", 32'(rsp_cf), 32'd0);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("t1_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Test 2: carry out from req1
        do_op(1, 16'hFFFF, 16'h0001, OP_ADD, "t2");

        // Test 3: both continuously valid, grants alternate starting at 0
        cnt[0] = 0; cnt[1] = 0;
        set_ops(0, 0); set_ops(1, 0);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (req_ready == 2'b00 && w < 20) begin
                @(negedge clk); #1;
                w++;
            end
            chk("t3_grant", 32'(req_ready), 32'd1 << (k % 2));
            g = req_ready[1] ? 1 : 0;
            e = alu_calc(req_op[g*4 +: 4], req_a[g*16 +: 16], req_b[g*16 +: 16]);
            @(negedge clk);
            cnt[g]++;
            if (cnt[g] == 4) req_valid[g] = 1'b0;
            else set_ops(g, cnt[g]);
            #1;
            wait_rsp();
            chk("t3_owner", 32'(rsp_valid), 32'd1 << g);
            chk("t3_result", 32'(rsp_result), 32'(e[15:0]));
            chk("t3_cf", 32'(rsp_cf), 32'(e[16]));
            rsp_ready = rsp_valid;
            @(negedge clk);
            rsp_ready = 2'b00;
            #1;
        end

        // Test 4: backpressure, non-owner rsp_ready ignored, req1 pending
        @(negedge clk);
        req_valid[0] = 1'b1; req_a[15:0] = 16'h00F0; req_b[15:0] = 16'h0FF0; req_op[3:0] = OP_XOR;
        #1;
        chk("t4_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_a[31:16] = 16'h1234; req_b[31:16] = 16'h0001; req_op[7:4] = OP_SUB;
        #1;
        wait_rsp();
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(rsp_valid), 32'h1);
            chk("t4_hold_result", 32'(rsp_result), 32'h0F00);
            chk("t4_hold_cf", 32'(rsp_cf), 32'd0);
            chk("t4_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk); #1;
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("t4_next_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        wait_rsp();
        chk("t4_owner1", 32'(rsp_valid), 32'h2);
        chk("t4_result1", 32'(rsp_result), 32'h1233);
        rsp_ready = rsp_valid;
        @(negedge clk);
        rsp_ready = 2'b00;

        // Test 5: ALU_LAT=3, capture exactly when the model output is valid
        @(negedge clk);
        req_valid3 = 2'b01; req_a3[15:0] = 16'h0003; req_b3[15:0] = 16'h0010; req_op3[3:0] = OP_SUB;
        #1;
        chk("t5_ready", 32'(req_ready3), 32'h1);
        @(negedge clk);
        req_valid3 = 2'b00;
        #1;
        chk("t5_enable", 32'(alu_enable3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t5_wait_enable", 32'(alu_enable3), 32'd0);
            chk("t5_wait_a", 32'(alu_data_a3), 32'h0003);
            chk("t5_wait_b", 32'(alu_data_b3), 32'h0010);
            chk("t5_wait_op", 32'(alu_opcode3), 32'(OP_SUB));
            chk("t5_wait_rsp", 32'(rsp_valid3), 32'd0);
        end
        @(negedge clk); #1;
        chk("t5_rsp_valid", 32'(rsp_valid3), 32'h1);
        chk("t5_result", 32'(rsp_result3), 32'hFFF3);
        chk("t5_cf", 32'(rsp_cf3), 32'd1);
        rsp_ready3 = 2'b01;
        @(negedge clk);
        rsp_ready3 = 2'b00;
        #1;
        chk("t5_idle", 32'(busy3), 32'd0);

        // Test 6: reset during WAIT aborts the op and restores priority to req0
        do_op(0, 16'h0100, 16'h0023, OP_OR, "t6pre");
        @(negedge clk);
        req_valid[1] = 1'b1; req_a[31:16] = 16'h5555; req_b[31:16] = 16'h0F0F; req_op[7:4] = OP_AND;
        #1;
        chk("t6_accept1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("t6_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_enable", 32'(alu_enable), 32'd0);
        chk("t6_rst_data_a", 32'(alu_data_a), 32'd0);
        chk("t6_rst_data_b", 32'(alu_data_b), 32'd0);
        chk("t6_rst_result", 32'(rsp_result), 32'd0);
        chk("t6_rst_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
            chk("t6_no_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        req_a[15:0] = 16'h0002; req_b[15:0] = 16'h0005; req_op[3:0] = OP_ADD;
        req_valid = 2'b11;
        #1;
        chk("t6_rr_after_rst", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        wait_rsp();
        chk("t6_owner", 32'(rsp_valid), 32'h1);
        chk("t6_result", 32'(rsp_result), 32'h0007);
        rsp_ready = rsp_valid;
        @(negedge clk);
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
